// File: rtl/adc_scanner_pkg.sv
// -----------------------------------------------------------------------------
// adc_scanner_pkg
// Shared definitions for the 4-channel SPI ADC scanner: controller state
// encoding, frame geometry, result width, channel count and the command
// prefix placed in front of the channel number on MOSI.
// -----------------------------------------------------------------------------
package adc_scanner_pkg;

  localparam int unsigned FRAME_BITS = 16;  // SCLK periods per conversion frame
  localparam int unsigned RESULT_W   = 12;  // conversion result width
  localparam int unsigned NUM_CH     = 4;   // channels scanned round-robin
  localparam int unsigned CH_W       = 2;   // channel index width

  // Start bit + single-ended select, sent ahead of the channel number.
  localparam logic [1:0] CMD_PREFIX = 2'b11;

  // A frame is 34 SCLK half-periods: one setup half, 32 shift halves
  // (high phase first) and one hold half with SCLK parked low.
  localparam int unsigned HALF_W         = 6;
  localparam int unsigned HALF_SHIFT_END = 2 * FRAME_BITS;      // last low phase
  localparam int unsigned HALF_HOLD      = 2 * FRAME_BITS + 1;  // hold phase

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // MOSI command word for a channel, sent MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [CH_W-1:0] ch);
    return {CMD_PREFIX, ch, {RESULT_W{1'b0}}};
  endfunction

  // Chip select is asserted for the whole of setup, shift and hold.
  function automatic logic is_frame_state(input state_t st);
    return (st == ST_SETUP) || (st == ST_SHIFT) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// -----------------------------------------------------------------------------
// adc_sclk_gen
// Half-period divider for the ADC serial clock. While run is high it counts
// CLK_DIV-cycle half-periods across one frame and emits single-cycle strobes
// marking where SCLK must rise or fall, where the shift phase ends and where
// the hold phase ends. Counters clear whenever run is low, so every frame
// starts from the same phase.
//
// Ports
//   clk24        system clock, rising edge
//   reset        asynchronous active-low reset
//   run_i        frame in progress (setup, shift or hold)
//   rise_o       SCLK goes high at the next clock edge
//   fall_o       SCLK goes low at the next clock edge
//   shift_end_o  last shift half-period completes at the next edge
//   frame_end_o  hold half-period completes at the next edge
// -----------------------------------------------------------------------------
module adc_sclk_gen
  import adc_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic clk24,
  input  logic reset,
  input  logic run_i,
  output logic rise_o,
  output logic fall_o,
  output logic shift_end_o,
  output logic frame_end_o
);

  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] SHIFT_END = HALF_W'(HALF_SHIFT_END);
  localparam logic [HALF_W-1:0] HOLD_HALF = HALF_W'(HALF_HOLD);

  logic [7:0]        div_cnt_q;
  logic [HALF_W-1:0] half_q;
  logic              tick;

  assign tick = run_i && (div_cnt_q == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk24 or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      half_q    <= '0;
    end else if (!run_i) begin
      div_cnt_q <= '0;
      half_q    <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
      half_q    <= (half_q == HOLD_HALF) ? '0 : half_q + 1'b1;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

  // Even half indices before the shift end lead into a high phase, odd ones
  // into a low phase: 16 rises and 16 falls per frame.
  assign rise_o      = tick && !half_q[0] && (half_q < SHIFT_END);
  assign fall_o      = tick &&  half_q[0] && (half_q < SHIFT_END);
  assign shift_end_o = tick && (half_q == SHIFT_END);
  assign frame_end_o = tick && (half_q == HOLD_HALF);

endmodule

// File: rtl/adc_scanner.sv
// -----------------------------------------------------------------------------
// adc_scanner
// Continuously scans a 4-channel SPI ADC (mode 0) while enable is high. Each
// frame sends {start, single-ended, channel, 12'h000} on MOSI and captures
// 16 MISO bits, keeping the last 12 as the channel result. Channels rotate
// 0..3 and the rotation point survives idle periods.
//
// Ports
//   clk24            system clock, rising edge
//   reset            asynchronous active-low reset
//   enable           keep scanning while high (a running frame always completes)
//   spi_cs_n         ADC chip select, active low
//   spi_sclk         ADC serial clock, idle low
//   spi_mosi         command bits to the ADC
//   spi_miso         data bits from the ADC
//   ch0..ch3         latest result per channel
//   frame_done       one-cycle pulse when a channel result updates
//   scan_done        one-cycle pulse when ch3 updates
// -----------------------------------------------------------------------------
module adc_scanner
  import adc_scanner_pkg::*;
#(
  parameter int unsigned CLK_DIV = 6,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic                clk24,
  input  logic                reset,
  input  logic                enable,
  output logic                spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [RESULT_W-1:0] ch0,
  output logic [RESULT_W-1:0] ch1,
  output logic [RESULT_W-1:0] ch2,
  output logic [RESULT_W-1:0] ch3,
  output logic                frame_done,
  output logic                scan_done
);

  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  state_t                state_q, state_d;
  logic [7:0]            gap_cnt_q;
  logic [CH_W-1:0]       ch_idx_q;
  logic [FRAME_BITS-1:0] mosi_sr_q;
  logic [FRAME_BITS-1:0] miso_sr_q;
  logic [RESULT_W-1:0]   ch_q [NUM_CH];
  logic                  cs_n_q, sclk_q, mosi_q;
  logic                  frame_done_q, scan_done_q;

  logic                  run;
  logic                  sclk_rise, sclk_fall, shift_end, frame_end;
  logic [FRAME_BITS-1:0] frame_cmd;
  logic                  unused_miso_hi;

  assign run       = is_frame_state(state_q);
  assign frame_cmd = build_frame(ch_idx_q);

  // The leading four MISO bits arrive while the command is still going out
  // and carry no data.
  assign unused_miso_hi = ^miso_sr_q[FRAME_BITS-1:RESULT_W];

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk24       (clk24),
    .reset       (reset),
    .run_i       (run),
    .rise_o      (sclk_rise),
    .fall_o      (sclk_fall),
    .shift_end_o (shift_end),
    .frame_end_o (frame_end)
  );

  always_ff @(posedge clk24 or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Enable is only consulted in IDLE and at the end of GAP, so dropping it
  // mid-frame lets the frame finish and its result land.
  // NOTE: state_d gets its default before the case so every path assigns it;
  // otherwise a latch is inferred for the uncovered conditions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable)    state_d = ST_SETUP;
      ST_SETUP: if (sclk_rise) state_d = ST_SHIFT;
      ST_SHIFT: if (shift_end) state_d = ST_HOLD;
      ST_HOLD:  if (frame_end) state_d = ST_GAP;
      ST_GAP:   if (gap_cnt_q == GAP_LAST) state_d = enable ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with state_q and
  // nothing reaches an output combinationally.
  // NOTE: the result registers are reset explicitly because software reads
  // them as a defined zero until the first conversion of each channel lands.
  always_ff @(posedge clk24 or negedge reset) begin
    if (!reset) begin
      gap_cnt_q    <= '0;
      ch_idx_q     <= '0;
      mosi_sr_q    <= '0;
      miso_sr_q    <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      frame_done_q <= 1'b0;
      scan_done_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      scan_done_q  <= 1'b0;
      cs_n_q       <= !is_frame_state(state_d);
      gap_cnt_q    <= (state_q == ST_GAP) ? gap_cnt_q + 8'd1 : '0;

      // Command bit 15 is presented for the whole setup half-period.
      if (state_q != ST_SETUP && state_d == ST_SETUP) begin
        mosi_sr_q <= frame_cmd;
        mosi_q    <= frame_cmd[FRAME_BITS-1];
      end

      if (sclk_rise) begin
        sclk_q    <= 1'b1;
        miso_sr_q <= {miso_sr_q[FRAME_BITS-2:0], spi_miso};
      end

      // After the 16th fall the shifter has emptied, so MOSI parks at 0.
      if (sclk_fall) begin
        sclk_q    <= 1'b0;
        mosi_q    <= mosi_sr_q[FRAME_BITS-2];
        mosi_sr_q <= {mosi_sr_q[FRAME_BITS-2:0], 1'b0};
      end

      if (frame_end) begin
        ch_q[ch_idx_q] <= miso_sr_q[RESULT_W-1:0];
        frame_done_q   <= 1'b1;
        scan_done_q    <= (ch_idx_q == LAST_CH);
        ch_idx_q       <= ch_idx_q + 1'b1;
      end
    end
  end

  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign ch0        = ch_q[0];
  assign ch1        = ch_q[1];
  assign ch2        = ch_q[2];
  assign ch3        = ch_q[3];
  assign frame_done = frame_done_q;
  assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_adc_scanner.sv
// -----------------------------------------------------------------------------
// tb_adc_scanner
// Self-checking bench for adc_scanner at default parameters. A behavioural
// ADC decodes the channel from MOSI and returns a per-channel value behind
// four filler bits; a table of scans supplies values and expected results,
// followed by hand-written reset-abort and enable-drop sequences.
// -----------------------------------------------------------------------------
module tb_adc_scanner;

  typedef struct packed {
    logic [3:0][11:0] adc;
    logic [3:0][11:0] exp_ch;
  } scan_vec_t;

  localparam logic [3:0] ADC_PAD = 4'b0101;

  logic        clk24 = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic [11:0] ch0, ch1, ch2, ch3;
  logic        frame_done, scan_done;

  always #5 clk24 = ~clk24;

  adc_scanner dut (
    .clk24      (clk24),
    .reset      (reset),
    .enable     (enable),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .frame_done (frame_done),
    .scan_done  (scan_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ADC model ----------------
  logic [11:0] adc_val [4];
  logic [15:0] m_word = '0;
  logic [3:0]  m_cmd = '0;
  int          m_rises = 0;
  int          m_falls = 0;
  logic        m_sclk_prev = 1'b0;
  logic        m_cs_prev = 1'b1;

  always @(negedge clk24) begin
    if (!spi_cs_n && m_cs_prev) begin
      m_rises  = 0;
      m_falls  = 0;
      m_cmd    = '0;
      m_word   = {ADC_PAD, 12'h000};
      spi_miso = m_word[15];
    end else if (!spi_cs_n) begin
      if (spi_sclk && !m_sclk_prev) begin
        m_rises++;
        if (m_rises <= 4) m_cmd = {m_cmd[2:0], spi_mosi};
      end
      if (!spi_sclk && m_sclk_prev) begin
        m_falls++;
        if (m_falls == 4) m_word[11:0] = adc_val[m_cmd[1:0]];
        spi_miso = (m_falls < 16) ? m_word[15 - m_falls] : 1'b0;
      end
    end
    m_sclk_prev = spi_sclk;
    m_cs_prev   = spi_cs_n;
  end

  // ---------------- Bus monitor ----------------
  logic [3:0][11:0] ch_now, ch_prev;
  assign ch_now = {ch3, ch2, ch1, ch0};

  function automatic int count_changes(input logic [3:0][11:0] a, input logic [3:0][11:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  int          cyc = 0, cs_fall_cyc = 0, rise_cyc = 0;
  int          period_last = 0, cs_low_last = 0, rises_last = 0, sclk_per_last = 0;
  int          rise_cur = 0, fd_count = 0, sd_count = 0;
  int          mosi_viol = 0, chg_viol = 0, sd_viol = 0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;
  logic [15:0] mosi_word = '0;
  logic [15:0] mosi_log [$];

  always @(negedge clk24) begin
    sclk_prev <= spi_sclk;
    cs_prev   <= spi_cs_n;
    mosi_prev <= spi_mosi;
    ch_prev   <= ch_now;
    cyc       <= cyc + 1;
    if (reset) begin
      if (!spi_cs_n && cs_prev) begin
        period_last <= cyc - cs_fall_cyc;
        cs_fall_cyc <= cyc;
        rise_cur    <= 0;
        mosi_word   <= '0;
      end
      if (spi_cs_n && !cs_prev) begin
        cs_low_last <= cyc - cs_fall_cyc;
        rises_last  <= rise_cur;
        mosi_log.push_back(mosi_word);
      end
      if (spi_sclk && !sclk_prev) begin
        rise_cur      <= rise_cur + 1;
        mosi_word     <= {mosi_word[14:0], spi_mosi};
        sclk_per_last <= cyc - rise_cyc;
        rise_cyc      <= cyc;
      end
      if (spi_mosi !== mosi_prev && !(sclk_prev && !spi_sclk) && !(!spi_cs_n && cs_prev))
        mosi_viol <= mosi_viol + 1;
      if (count_changes(ch_now, ch_prev) > 1 ||
          (count_changes(ch_now, ch_prev) == 1 && !frame_done))
        chg_viol <= chg_viol + 1;
      if (frame_done) fd_count <= fd_count + 1;
      if (scan_done)  sd_count <= sd_count + 1;
      if (scan_done && !frame_done) sd_viol <= sd_viol + 1;
    end
  end

  // ---------------- Bounded waits ----------------
  task automatic wait_frame_done(input string name, input int limit);
    int n = 0;
    @(negedge clk24);
    while (!frame_done && n < limit) begin
      @(negedge clk24);
      n++;
    end
    check(name, frame_done, 1'b1);
  endtask

  task automatic wait_scan_done(input string name, input int limit);
    int n = 0;
    @(negedge clk24);
    while (!scan_done && n < limit) begin
      @(negedge clk24);
      n++;
    end
    check(name, scan_done, 1'b1);
  endtask

  task automatic wait_rise(input string name, input int k, input int limit);
    int n = 0;
    @(negedge clk24);
    while (!(rise_cur == k && !spi_cs_n) && n < limit) begin
      @(negedge clk24);
      n++;
    end
    check(name, (rise_cur == k && !spi_cs_n), 1'b1);
  endtask

  function automatic scan_vec_t mk_vec(input logic [11:0] a0, a1, a2, a3, e0, e1, e2, e3);
    scan_vec_t v;
    v.adc[0] = a0; v.adc[1] = a1; v.adc[2] = a2; v.adc[3] = a3;
    v.exp_ch[0] = e0; v.exp_ch[1] = e1; v.exp_ch[2] = e2; v.exp_ch[3] = e3;
    return v;
  endfunction

  // ---------------- Stimulus ----------------
  scan_vec_t   vecs [5];
  logic [15:0] mosi_exp [4] = '{16'hC000, 16'hD000, 16'hE000, 16'hF000};

  initial begin
    int base, fd0, sd0;

    vecs[0] = mk_vec(12'hA5C, 12'h3F1, 12'h000, 12'hFFF, 12'hA5C, 12'h3F1, 12'h000, 12'hFFF);
    vecs[1] = mk_vec(12'h111, 12'h222, 12'h333, 12'h444, 12'h111, 12'h222, 12'h333, 12'h444);
    vecs[2] = mk_vec(12'h800, 12'h001, 12'h7FE, 12'h555, 12'h800, 12'h001, 12'h7FE, 12'h555);
    vecs[3] = mk_vec(12'h0F0, 12'hF0F, 12'hABC, 12'h123, 12'h0F0, 12'hF0F, 12'hABC, 12'h123);
    vecs[4] = mk_vec(12'hFFF, 12'h000, 12'hA5C, 12'h3F1, 12'hFFF, 12'h000, 12'hA5C, 12'h3F1);
    for (int i = 0; i < 4; i++) adc_val[i] = 12'h000;

    // Reset values
    repeat (3) @(negedge clk24);
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_ch0", ch0, 12'h000);
    check("rst_ch1", ch1, 12'h000);
    check("rst_ch2", ch2, 12'h000);
    check("rst_ch3", ch3, 12'h000);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);

    // Reset asserted mid-frame around sclk rise 10 of the first ch0 frame
    adc_val[0] = 12'hBAD;
    #2 reset = 1'b1;
    enable = 1'b1;
    wait_rise("abort_reach_rise10", 10, 400);
    check("abort_sclk_high_before", spi_sclk, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_cs_n", spi_cs_n, 1'b1);
    check("abort_sclk", spi_sclk, 1'b0);
    check("abort_mosi", spi_mosi, 1'b0);
    check("abort_ch0", ch0, 12'h000);
    repeat (4) @(negedge clk24);
    check("abort_ch0_hold", ch0, 12'h000);
    check("abort_frame_done", frame_done, 1'b0);
    #2 reset = 1'b1;

    // Table-driven scans with enable held
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) adc_val[i] = vecs[r].adc[i];
      base = mosi_log.size();
      fd0  = fd_count;
      sd0  = sd_count;
      wait_scan_done($sformatf("scan%0d_done", r), 1200);
      @(negedge clk24);
      check($sformatf("scan%0d_frame_pulses", r), fd_count - fd0, 4);
      check($sformatf("scan%0d_scan_pulses", r), sd_count - sd0, 1);
      check($sformatf("scan%0d_ch0", r), ch0, vecs[r].exp_ch[0]);
      check($sformatf("scan%0d_ch1", r), ch1, vecs[r].exp_ch[1]);
      check($sformatf("scan%0d_ch2", r), ch2, vecs[r].exp_ch[2]);
      check($sformatf("scan%0d_ch3", r), ch3, vecs[r].exp_ch[3]);
      check($sformatf("scan%0d_mosi_frames", r), mosi_log.size() - base, 4);
      if (mosi_log.size() >= base + 4)
        for (int f = 0; f < 4; f++)
          check($sformatf("scan%0d_mosi_f%0d", r, f), mosi_log[base + f], mosi_exp[f]);
      if (r == 0) begin
        check("timing_cs_low", cs_low_last, 204);
        check("timing_period", period_last, 208);
        check("timing_rises", rises_last, 16);
        check("timing_sclk_period", sclk_per_last, 12);
      end
    end

    // Enable dropped at sclk rise 5 of the ch1 frame
    adc_val[0] = 12'h9AB;
    adc_val[1] = 12'h123;
    adc_val[2] = 12'h456;
    adc_val[3] = 12'h789;
    wait_frame_done("drop_ch0_done", 400);
    @(negedge clk24);
    check("drop_ch0", ch0, 12'h9AB);
    wait_rise("drop_reach_rise5", 5, 400);
    enable = 1'b0;
    wait_frame_done("drop_ch1_done", 400);
    @(negedge clk24);
    check("drop_ch1", ch1, 12'h123);
    check("drop_ch2_held", ch2, 12'hA5C);
    fd0 = fd_count;
    repeat (300) @(negedge clk24);
    check("drop_idle_cs_n", spi_cs_n, 1'b1);
    check("drop_idle_sclk", spi_sclk, 1'b0);
    check("drop_idle_no_frames", fd_count - fd0, 0);
    base = mosi_log.size();
    enable = 1'b1;
    wait_frame_done("resume_done", 400);
    @(negedge clk24);
    check("resume_mosi_frames", mosi_log.size() - base, 1);
    if (mosi_log.size() > base) check("resume_mosi_ch2", mosi_log[base], 16'hE000);
    check("resume_ch2", ch2, 12'h456);
    check("resume_ch1_held", ch1, 12'h123);
    enable = 1'b0;

    check("mosi_stable_at_rises", mosi_viol, 0);
    check("ch_update_discipline", chg_viol, 0);
    check("scan_done_with_frame_done", sd_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
